// File: rtl/mac_pkg.sv
// Shared constants, state encoding and instruction encodings for the
// MAC matrix sequencer.
package mac_pkg;

  localparam int DATA_SIZE = 8;
  localparam int MAC_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic INSTR_LOAD_W  = 1'b1;
  localparam logic INSTR_COMPUTE = 1'b0;

endpackage

// File: rtl/mac_skew_buffer.sv
// Diagonal skew for the matrix west edge: lane i of the input vector is
// delayed by i+1 cycles so that each row of the array sees its operand
// one cycle after the row above it.
module mac_skew_buffer #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LANES*LANE_W-1:0]   din,
  output logic [LANES*LANE_W-1:0]   dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] dly_p [i+1];

    // Lane i shift register, i+1 stages deep; cleared on reset.
    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int k = 0; k <= i; k++) dly_p[k] <= '0;
      end else begin
        dly_p[0] <= din[i*LANE_W +: LANE_W];
        for (int k = 1; k <= i; k++) dly_p[k] <= dly_p[k-1];
      end
    end

    assign dout[i*LANE_W +: LANE_W] = dly_p[i];
  end

endmodule

// File: rtl/mac_matrix_ctrl.sv
// Sequencer for the square systolic MAC matrix: loads the weight image one
// row per cycle, streams skewed activation vectors onto the west edge,
// drains the array and flags each result at the south edge.
// Optional build macro MAC_CTRL_DUAL_STREAM_EN adds a second activation
// stream (act2_data) skewed onto values_in2; otherwise values_in2 is 0.
module mac_matrix_ctrl #(
  parameter int DATA_SIZE = mac_pkg::DATA_SIZE,
  parameter int MAC_WIDTH = mac_pkg::MAC_WIDTH,
  parameter int CNT_W     = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [CNT_W-1:0]                         num_vectors,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     wbuf_rd_en,
  output logic [$clog2(MAC_WIDTH)-1:0]             wbuf_rd_addr,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0]           wbuf_rd_data,
  output logic [MAC_WIDTH*MAC_WIDTH*DATA_SIZE-1:0] weights_data_out,
  output logic                                     weights_load,
  output logic                                     instr,
  input  logic                                     act_valid,
  output logic                                     act_ready,
  input  logic [2*MAC_WIDTH*DATA_SIZE-1:0]         act_data,
`ifdef MAC_CTRL_DUAL_STREAM_EN
  input  logic [2*MAC_WIDTH*DATA_SIZE-1:0]         act2_data,
`endif
  output logic [2*MAC_WIDTH*DATA_SIZE-1:0]         values_in1,
  output logic [2*MAC_WIDTH*DATA_SIZE-1:0]         values_in2,
  output logic                                     result_valid
);

  import mac_pkg::*;

  localparam int ADDR_W = $clog2(MAC_WIDTH);
  localparam int ROW_W  = MAC_WIDTH * DATA_SIZE;
  localparam int LANE_W = 2 * DATA_SIZE;
  localparam int VEC_W  = MAC_WIDTH * LANE_W;
  localparam int PH_W   = $clog2(2 * MAC_WIDTH) + 1;
  localparam int LAT    = 2 * MAC_WIDTH;

  state_t                     state;
  logic [PH_W-1:0]            phase;
  logic [CNT_W-1:0]           vec_cnt;
  logic                       accept;
  logic                       rd_en_p1;
  logic [ADDR_W-1:0]          rd_addr_p1;
  logic [MAC_WIDTH*ROW_W-1:0] weights_p2;
  logic [LAT-1:0]             vld_pipe;
  logic [VEC_W-1:0]           act_in;

  // Handshake and weight-read strobes decoded from the current state.
  always_comb begin
    accept       = (state == STREAM) && act_valid;
    wbuf_rd_en   = (state == LOAD_W) && (phase < PH_W'(MAC_WIDTH));
    wbuf_rd_addr = wbuf_rd_en ? phase[ADDR_W-1:0] : '0;
    weights_load = (state == LOAD_W) && (phase == PH_W'(MAC_WIDTH + 1));
    instr        = (state == LOAD_W) ? INSTR_LOAD_W : INSTR_COMPUTE;
    act_ready    = (state == STREAM);
    busy         = (state == LOAD_W) || (state == STREAM) || (state == DRAIN);
    done         = (state == DONE);
    act_in       = accept ? act_data : '0;
  end

  // Job sequencing: phase counts LOAD_W and DRAIN cycles, vec_cnt counts
  // the beats still owed; it never decrements below zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      vec_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            phase   <= '0;
            vec_cnt <= num_vectors;
            state   <= (num_vectors == '0) ? DONE : LOAD_W;
          end
        end
        LOAD_W: begin
          if (phase == PH_W'(MAC_WIDTH + 1)) begin
            phase <= '0;
            state <= STREAM;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            if (vec_cnt != '0) vec_cnt <= vec_cnt - 1'b1;
            if (vec_cnt < CNT_W'(2)) begin
              phase <= '0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (phase == PH_W'(LAT - 1)) state <= DONE;
          else                         phase <= phase + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Weight capture one cycle after each read, plus the result-valid delay
  // line that tracks accepted beats through the skew and the array.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_en_p1   <= 1'b0;
      rd_addr_p1 <= '0;
      weights_p2 <= '0;
      vld_pipe   <= '0;
    end else begin
      rd_en_p1   <= wbuf_rd_en;
      rd_addr_p1 <= wbuf_rd_addr;
      if (rd_en_p1) weights_p2[rd_addr_p1*ROW_W +: ROW_W] <= wbuf_rd_data;
      vld_pipe   <= {vld_pipe[LAT-2:0], accept};
    end
  end

  assign weights_data_out = weights_p2;
  assign result_valid     = vld_pipe[LAT-1];

  mac_skew_buffer #(.LANES(MAC_WIDTH), .LANE_W(LANE_W)) u_skew1 (
    .clock (clock),
    .reset (reset),
    .din   (act_in),
    .dout  (values_in1)
  );

`ifdef MAC_CTRL_DUAL_STREAM_EN
  logic [VEC_W-1:0] act2_in;

  // Second stream rides the same handshake as the first.
  always_comb begin
    act2_in = accept ? act2_data : '0;
  end

  mac_skew_buffer #(.LANES(MAC_WIDTH), .LANE_W(LANE_W)) u_skew2 (
    .clock (clock),
    .reset (reset),
    .din   (act2_in),
    .dout  (values_in2)
  );
`else
  assign values_in2 = '0;
`endif

endmodule

// File: tb/tb_mac_matrix_ctrl.sv
// Directed bench for mac_matrix_ctrl: reset, empty job, weight load,
// streaming with and without bubbles, skew timing and mid-job reset.
module tb_mac_matrix_ctrl;

  localparam int DS = 8;
  localparam int MW = 8;
  localparam int LW = 2 * DS;
  localparam int VW = MW * LW;
  localparam int RW = MW * DS;
  localparam int CW = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [CW-1:0]     num_vectors;
  logic              busy, done, wbuf_rd_en, weights_load, instr;
  logic [2:0]        wbuf_rd_addr;
  logic [RW-1:0]     wbuf_rd_data;
  logic [MW*RW-1:0]  weights_data_out;
  logic              act_valid, act_ready, result_valid;
  logic [VW-1:0]     act_data, act2_data, values_in1, values_in2;

  int checks = 0;
  int errors = 0;
  int rd_cnt, load_cnt, load_cyc, done_cyc, busy_low;
  int acc_q[$];
  int res_q[$];

  mac_matrix_ctrl #(.DATA_SIZE(DS), .MAC_WIDTH(MW), .CNT_W(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .num_vectors      (num_vectors),
    .busy             (busy),
    .done             (done),
    .wbuf_rd_en       (wbuf_rd_en),
    .wbuf_rd_addr     (wbuf_rd_addr),
    .wbuf_rd_data     (wbuf_rd_data),
    .weights_data_out (weights_data_out),
    .weights_load     (weights_load),
    .instr            (instr),
    .act_valid        (act_valid),
    .act_ready        (act_ready),
    .act_data         (act_data),
`ifdef MAC_CTRL_DUAL_STREAM_EN
    .act2_data        (act2_data),
`endif
    .values_in1       (values_in1),
    .values_in2       (values_in2),
    .result_valid     (result_valid)
  );

  always #5 clock = ~clock;

  // Weight buffer: row r holds byte r+1 in every element, one-cycle latency.
  always @(posedge clock) begin
    wbuf_rd_data <= wbuf_rd_en ? {MW{8'(wbuf_rd_addr) + 8'd1}} : '0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  function automatic bit accepted_at(input int cyc);
    foreach (acc_q[j]) if (acc_q[j] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_rd_en"},  wbuf_rd_en, 0);
    chk({tag, "_rd_addr"}, wbuf_rd_addr, 0);
    chk({tag, "_wload"},  weights_load, 0);
    chk({tag, "_instr"},  instr, 0);
    chk({tag, "_ready"},  act_ready, 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_vin1"},   |values_in1, 0);
    chk({tag, "_vin2"},   |values_in2, 0);
    chk({tag, "_wdata"},  |weights_data_out, 0);
  endtask

  // Runs one job starting in the current cycle (cycle 0). vmask bit j is
  // act_valid in cycle 11+j, the first expected STREAM cycle.
  task automatic run_job(input int n, input logic [31:0] vmask);
    int  k;
    bit  fin;
    logic [15:0] exp1, exp2;
    rd_cnt = 0; load_cnt = 0; load_cyc = -1; done_cyc = -1; busy_low = 0;
    acc_q.delete(); res_q.delete();
    start = 1'b1; num_vectors = CW'(n);
    step();
    start = 1'b0; num_vectors = '0;
    k = 1; fin = 1'b0;
    while (!fin && k <= 90) begin
      act_valid = (k >= 11 && k < 43) ? vmask[k-11] : 1'b0;
      for (int i = 0; i < MW; i++) begin
        exp1 = accepted_at(k - i - 1) ? 16'(i + 1) : 16'h0;
`ifdef MAC_CTRL_DUAL_STREAM_EN
        exp2 = accepted_at(k - i - 1) ? 16'(16'h10 + i) : 16'h0;
`else
        exp2 = 16'h0;
`endif
        chk($sformatf("vin1_c%0d_l%0d", k, i), values_in1[i*LW +: LW], exp1);
        chk($sformatf("vin2_c%0d_l%0d", k, i), values_in2[i*LW +: LW], exp2);
      end
      if (wbuf_rd_en) begin
        chk("rd_addr", wbuf_rd_addr, rd_cnt);
        rd_cnt++;
      end
      if (weights_load) begin
        load_cnt++;
        load_cyc = k;
        chk("wload_instr", instr, 1);
        for (int r = 0; r < MW; r++)
          chk($sformatf("wrow%0d", r), weights_data_out[r*RW +: RW], {MW{8'(r + 1)}});
      end
      if (act_ready && act_valid) acc_q.push_back(k);
      if (result_valid) res_q.push_back(k);
      if (done) begin
        done_cyc = k;
        chk("busy_at_done", busy, 0);
        fin = 1'b1;
      end else if (!busy) begin
        busy_low++;
      end
      step();
      k++;
    end
    act_valid = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n_done;
    reset = 1'b0; start = 1'b0; num_vectors = '0; act_valid = 1'b0;
    for (int i = 0; i < MW; i++) begin
      act_data[i*LW +: LW]  = 16'(i + 1);
      act2_data[i*LW +: LW] = 16'(16'h10 + i);
    end
    step(); step(); step();
    chk_quiet("reset");
    reset = 1'b1;
    step();

    // Empty job: straight to DONE, no reads, no weight load.
    run_job(0, 32'h0);
    chk("empty_done_cyc", done_cyc, 1);
    chk("empty_rd_cnt",   rd_cnt, 0);
    chk("empty_load_cnt", load_cnt, 0);
    chk("empty_done_low", done, 0);

    // Three back-to-back beats.
    run_job(3, 32'hFFFF_FFFF);
    chk("j3_rd_cnt",   rd_cnt, 8);
    chk("j3_load_cnt", load_cnt, 1);
    chk("j3_load_cyc", load_cyc, 10);
    chk("j3_acc_n",    acc_q.size(), 3);
    chk("j3_acc0",     qget(acc_q, 0), 11);
    chk("j3_acc2",     qget(acc_q, 2), 13);
    chk("j3_res_n",    res_q.size(), 3);
    chk("j3_res0",     qget(res_q, 0), 27);
    chk("j3_res1",     qget(res_q, 1), 28);
    chk("j3_res2",     qget(res_q, 2), 29);
    chk("j3_done_cyc", done_cyc, 30);
    chk("j3_busy_low", busy_low, 0);

    // Single vector: skew timing is checked lane by lane inside run_job.
    run_job(1, 32'hFFFF_FFFF);
    chk("j1_acc0",     qget(acc_q, 0), 11);
    chk("j1_res_n",    res_q.size(), 1);
    chk("j1_res0",     qget(res_q, 0), 27);
    chk("j1_done_cyc", done_cyc, 28);

    // Bubble between two beats: 1,0,1,0 on act_valid.
    run_job(2, 32'h0000_0005);
    chk("jb_acc_n",    acc_q.size(), 2);
    chk("jb_acc1",     qget(acc_q, 1), 13);
    chk("jb_res_n",    res_q.size(), 2);
    chk("jb_res0",     qget(res_q, 0), 27);
    chk("jb_res1",     qget(res_q, 1), 29);
    chk("jb_done_cyc", done_cyc, 30);
    chk("jb_busy_low", busy_low, 0);

    // Reset in the middle of STREAM aborts the job silently.
    start = 1'b1; num_vectors = 16'd5;
    step();
    start = 1'b0; num_vectors = '0;
    for (int k = 1; k < 12; k++) begin
      act_valid = 1'b1;
      step();
    end
    chk("mid_ready", act_ready, 1);
    reset = 1'b0;
    step();
    chk_quiet("mid_rst");
    reset = 1'b1;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done) n_done++;
    end
    act_valid = 1'b0;
    chk("abort_no_done", n_done, 0);

    run_job(1, 32'hFFFF_FFFF);
    chk("post_res_n",    res_q.size(), 1);
    chk("post_res0",     qget(res_q, 0), 27);
    chk("post_done_cyc", done_cyc, 28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
